// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch stage: default widths and FSM state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package inst_fetch_pkg;

    // Default program address width; must track the pc address width.
    localparam int INST_DEPTH = 8;
    // Default instruction word width.
    localparam int INST_WIDTH = 16;

    // Fetch FSM states. The 2-bit encodings are shared with other blocks
    // that decode the fetch state, so the values are fixed.
    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_FULL  = 2'd2,
        FETCH_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Fetch stage: reads the word at pc_addr over mem_req/mem_ack and holds it in a one-entry IR for the decoder.
// Latency: capture -> ir_valid is 2 cycles with a zero-wait memory; 1 instruction per 3 cycles sustained.
// Backpressure: ir_ready low holds the IR and stops new requests; flush kills in-flight or buffered words.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = INST_DEPTH,
    parameter int INST_W = INST_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_count,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_data,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [INST_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_addr
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic              pc_count_nxt;
    logic              mem_req_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              ir_valid_nxt;
    logic [INST_W-1:0] ir_data_nxt;
    logic [ADDR_W-1:0] ir_addr_nxt;

    // State and every output are registered; reset drops everything to IDLE at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH_IDLE;
            pc_count <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            ir_valid <= 1'b0;
            ir_data  <= '0;
            ir_addr  <= '0;
        end else begin
            state    <= state_nxt;
            pc_count <= pc_count_nxt;
            mem_req  <= mem_req_nxt;
            mem_addr <= mem_addr_nxt;
            ir_valid <= ir_valid_nxt;
            ir_data  <= ir_data_nxt;
            ir_addr  <= ir_addr_nxt;
        end
    end

    // Next-state and next-output logic; registers hold unless a state says otherwise,
    // and pc_count defaults low so it can only ever be a single-cycle pulse.
    always_comb begin
        state_nxt    = state;
        pc_count_nxt = 1'b0;
        mem_req_nxt  = mem_req;
        mem_addr_nxt = mem_addr;
        ir_valid_nxt = ir_valid;
        ir_data_nxt  = ir_data;
        ir_addr_nxt  = ir_addr;

        unique case (state)
            FETCH_IDLE: begin
                // A flushing cycle is skipped so the capture sees the branch target.
                if (run && !flush) begin
                    mem_addr_nxt = pc_addr;
                    mem_req_nxt  = 1'b1;
                    state_nxt    = FETCH_REQ;
                end
            end

            FETCH_REQ: begin
                if (mem_ack && !flush) begin
                    ir_data_nxt  = mem_data;
                    ir_addr_nxt  = mem_addr;
                    ir_valid_nxt = 1'b1;
                    mem_req_nxt  = 1'b0;
                    pc_count_nxt = 1'b1;
                    state_nxt    = FETCH_FULL;
                end else if (mem_ack) begin
                    // Flush landed with the data: drop it, the pc is already reloading.
                    mem_req_nxt = 1'b0;
                    state_nxt   = FETCH_IDLE;
                end else if (flush) begin
                    // The read is already on the bus and must be allowed to finish.
                    state_nxt = FETCH_DRAIN;
                end
            end

            FETCH_DRAIN: begin
                // Stale read completes and is thrown away; no pc advance from here.
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = FETCH_IDLE;
                end
            end

            FETCH_FULL: begin
                // Either the decoder takes the word or a flush discards it.
                if (flush || ir_ready) begin
                    ir_valid_nxt = 1'b0;
                    state_nxt    = FETCH_IDLE;
                end
            end

            default: begin
                state_nxt = FETCH_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch with a pc model, a memory responder and a handshake-level reference.
// Latency: n/a.
// Backpressure: ir_ready and mem_ack wait states are randomized per phase.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        run;
    logic        flush;
    logic [7:0]  pc_addr;
    logic        pc_count;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_data;
    logic [7:0]  ir_addr;

    inst_fetch #(.ADDR_W(8), .INST_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .flush    (flush),
        .pc_addr  (pc_addr),
        .pc_count (pc_count),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .ir_data  (ir_data),
        .ir_addr  (ir_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Program memory contents.
    logic [15:0] mem_arr [256];

    // Stimulus knobs (percentages / max wait states).
    int run_pct, flush_pct, ready_pct, spur_pct, wait_max;

    // Memory responder state.
    bit in_txn;
    int wait_left;

    // Reference state: previous-cycle observations and inputs.
    logic        p_req, p_ack, p_flush, p_run, p_ready, p_valid;
    logic [7:0]  p_addr, p_ira, p_pc;
    logic [15:0] p_ird, ack_dat;
    bit          killed;
    int          since;
    logic [7:0]  exp_addr;
    int          n_xfer = 0;

    task automatic reset_model();
        p_req = 0; p_ack = 0; p_flush = 0; p_run = 0; p_ready = 0; p_valid = 0;
        p_addr = 0; p_ira = 0; p_pc = 0; p_ird = 0; ack_dat = 0;
        killed = 0; since = 100; exp_addr = 8'h00;
        in_txn = 0; wait_left = 0;
    endtask

    // One cycle: called at a negedge; checks outputs against last cycle, drives new inputs.
    task automatic step();
        logic [7:0] target;
        logic [7:0] pc_nxt;
        since++;

        if (p_req && !p_ack) begin
            chk("req_hold", 32'(mem_req), 32'd1);
            chk("addr_hold", 32'(mem_addr), 32'(p_addr));
            chk("no_ir_in_req", 32'(ir_valid), 32'd0);
        end
        if (p_req && p_ack) begin
            chk("req_drop", 32'(mem_req), 32'd0);
            chk("ir_load", 32'(ir_valid), 32'(!killed));
            if (!killed) begin
                chk("ir_data_load", 32'(ir_data), 32'(ack_dat));
                chk("ir_addr_load", 32'(ir_addr), 32'(p_addr));
            end
        end
        if (!p_req && !p_valid) begin
            chk("issue", 32'(mem_req), 32'(p_run && !p_flush));
            chk("idle_no_ir", 32'(ir_valid), 32'd0);
            if (mem_req) begin
                chk("cap_addr", 32'(mem_addr), 32'(p_pc));
                chk("spacing", 32'(since >= 2), 32'd1);
            end
        end
        if (p_valid) begin
            chk("full_no_req", 32'(mem_req), 32'd0);
            if (p_ready || p_flush) begin
                chk("ir_clear", 32'(ir_valid), 32'd0);
            end else begin
                chk("ir_hold", 32'(ir_valid), 32'd1);
                chk("ir_data_hold", 32'(ir_data), 32'(p_ird));
                chk("ir_addr_hold", 32'(ir_addr), 32'(p_ira));
            end
        end
        chk("pc_count", 32'(pc_count), 32'(ir_valid && !p_valid));
        if (pc_count) since = 0;

        // New inputs for this cycle.
        run      = ($urandom_range(0, 99) < run_pct);
        flush    = ($urandom_range(0, 99) < flush_pct);
        target   = 8'($urandom_range(0, 255));
        ir_ready = ($urandom_range(0, 99) < ready_pct);
        if (mem_req) begin
            if (!in_txn) begin
                in_txn    = 1;
                wait_left = $urandom_range(0, wait_max);
            end
            if (wait_left == 0) begin
                mem_ack  = 1'b1;
                mem_data = mem_arr[mem_addr];
                in_txn   = 0;
            end else begin
                mem_ack  = 1'b0;
                mem_data = 16'($urandom);
                wait_left--;
            end
        end else begin
            mem_ack  = ($urandom_range(0, 99) < spur_pct);
            mem_data = 16'($urandom);
            in_txn   = 0;
        end

        // Instruction stream: accepted words run sequentially from the last branch target.
        if (ir_valid && ir_ready && !flush) begin
            chk("xfer_addr", 32'(ir_addr), 32'(exp_addr));
            chk("xfer_data", 32'(ir_data), 32'(mem_arr[ir_addr]));
            exp_addr = ir_addr + 8'd1;
            n_xfer++;
        end
        if (flush) exp_addr = target;
        if (mem_req && !p_req) killed = 0;
        if (mem_req && flush) killed = 1;

        // pc: load beats count.
        pc_nxt = flush ? target : (pc_count ? 8'(pc_addr + 8'd1) : pc_addr);

        p_req = mem_req; p_ack = mem_ack; p_flush = flush; p_run = run;
        p_ready = ir_ready; p_valid = ir_valid; p_addr = mem_addr;
        p_ird = ir_data; p_ira = ir_addr; p_pc = pc_addr; ack_dat = mem_data;

        @(posedge clk);
        #1;
        pc_addr = pc_nxt;
        @(negedge clk);
    endtask

    task automatic set_knobs(input int r, input int f, input int rd, input int s, input int w);
        run_pct = r; flush_pct = f; ready_pct = rd; spur_pct = s; wait_max = w;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_req"},  32'(mem_req),  32'd0);
        chk({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
        chk({tag, "_pc_count"}, 32'(pc_count), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_ir_data"},  32'(ir_data),  32'd0);
        chk({tag, "_ir_addr"},  32'(ir_addr),  32'd0);
    endtask

    initial begin
        int x0;
        bit seen;
        rst = 1'b0; run = 0; flush = 0; pc_addr = 8'h00;
        mem_ack = 0; mem_data = 16'h0000; ir_ready = 0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'($urandom);
        mem_arr[0] = 16'hA5A5;
        reset_model();
        set_knobs(0, 0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst_init");
        rst = 1'b1;

        // Zero-wait, always-ready, no flush: one instruction every 3 cycles.
        set_knobs(100, 0, 100, 0, 0);
        x0 = n_xfer;
        for (int i = 0; i < 30; i++) step();
        chk("throughput", 32'(n_xfer - x0), 32'd10);

        // Wait states.
        set_knobs(90, 0, 70, 0, 4);
        for (int i = 0; i < 300; i++) step();

        // Heavy decoder backpressure.
        set_knobs(90, 0, 15, 10, 2);
        for (int i = 0; i < 300; i++) step();

        // Flushes everywhere, spurious acks, run toggling.
        set_knobs(75, 15, 60, 25, 3);
        for (int i = 0; i < 3000; i++) step();

        // Asynchronous reset in the middle of a read.
        set_knobs(100, 0, 50, 0, 20);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            if (mem_req) seen = 1;
        end
        chk("rst_setup_req", 32'(seen), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        run = 0; flush = 0; mem_ack = 0; ir_ready = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        pc_addr = 8'h00;
        reset_model();

        // Mixed traffic after the mid-read reset.
        set_knobs(60, 10, 50, 20, 3);
        for (int i = 0; i < 1000; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Fetch stage directly downstream of the program counter `pc`.
- Takes the current PC address and reads the instruction from program memory over a req/ack handshake.
- Holds the instruction in a one-entry instruction register (IR) and hands it to the decoder over a valid/ready handshake.
- Pulses `pc_count` once per accepted instruction.
- On `flush` (taken branch or jump), discards any in-flight or buffered instruction.

Parameters:
ADDR_W, default `INST_DEPTH (8), program address width; must match the `pc` addr width.
INST_W, default `INST_WIDTH (16), instruction word width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
run  in  1  fetch enable
flush  in  1  synchronous discard; the `pc` load happens in the same cycle
pc_addr  in  ADDR_W  current program address from `pc` addr_out
pc_count  out  1  one-cycle advance pulse to `pc` count
mem_req  out  1  program memory read request
mem_addr  out  ADDR_W  read address, stable while mem_req=1
mem_ack  in  1  read done; mem_data valid in the same cycle
mem_data  in  INST_W  read data
ir_valid  out  1  IR holds a valid instruction
ir_ready  in  1  decoder accepts the IR
ir_data  out  INST_W  instruction
ir_addr  out  ADDR_W  address of the instruction

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to IDLE immediately, including mid-transaction.
  - mem_req, pc_count and ir_valid go to 0; mem_addr, ir_data and ir_addr go to 0.
- All outputs are registered.
- States: IDLE, REQ, FULL, DRAIN.
- IDLE:
  - If run=1 and flush=0: capture pc_addr into mem_addr, set mem_req=1, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req and mem_addr are held until mem_ack. mem_ack may arrive in the first REQ cycle (zero-wait memory).
  - On mem_ack with flush=0:
    - ir_data←mem_data, ir_addr←mem_addr.
    - ir_valid=1 and mem_req=0 on the next edge.
    - pc_count=1 for exactly that one following cycle.
    - Go to FULL.
  - On flush without mem_ack: go to DRAIN (the request is already issued and must complete).
  - On flush together with mem_ack: drop the data, no pc_count, mem_req=0, go to IDLE.
- DRAIN:
  - mem_req is held until mem_ack. On mem_ack, discard the data, mem_req=0, go to IDLE.
  - flush in DRAIN has no extra effect.
  - pc_count is never asserted from DRAIN.
- FULL:
  - ir_data and ir_addr are stable while ir_valid=1.
  - A transfer occurs on ir_valid & ir_ready & ~flush. On transfer: ir_valid=0, go to IDLE.
  - flush in FULL: ir_valid=0 next cycle, go to IDLE, and the instruction is not considered transferred. The decoder qualifies acceptance with ~flush.
- Minimum spacing: the next IDLE→REQ capture occurs at least 2 cycles after pc_count, so pc_addr is already incremented.
- Zero-wait throughput: 1 instruction per 3 cycles.
- run=0 does not abort a transaction: REQ and DRAIN complete and FULL holds. No new request is issued from IDLE.
- ir_ready is ignored while ir_valid=0.
- mem_ack is ignored while mem_req=0.
- If flush coincides with pc_count=1, `pc` gives load priority over count, so the PC takes the branch target.

Decomposition:
- `defs.v` holds `INST_DEPTH`, `INST_WIDTH` and the 2-bit state encodings: FETCH_IDLE=0, FETCH_REQ=1, FETCH_FULL=2, FETCH_DRAIN=3.
- No sub-module. A single FSM plus the IR registers, about 150–200 lines.

Test Plan:
1. Reset: assert rst=0 while in REQ with mem_req=1 → mem_req, ir_valid and pc_count read 0 before the next clk edge; state is IDLE after release.
2. Zero-wait fetch: run=1, pc_addr=0x00, mem_ack in the first REQ cycle with mem_data=0xA5A5 → ir_valid=1, ir_data=0xA5A5, ir_addr=0x00, a single pc_count pulse; with ir_ready=1 the next mem_addr=0x01 (with a `pc` model).
3. Wait states: mem_ack 3 cycles after mem_req → mem_req=1 and mem_addr=0x05 constant for 3 cycles; exactly one pc_count pulse.
4. Backpressure: ir_ready=0 for 5 cycles with ir_valid=1 → ir_data and ir_addr held, mem_req=0 throughout; after ir_ready=1, a transfer and then the next request.
5. Flush in REQ: flush one cycle before mem_ack (mem_data=0xDEAD), `pc` loads 0x3F → no ir_valid, no pc_count, DRAIN until ack, then a request at mem_addr=0x3F.
6. Flush in FULL with ir_ready=1 in the same cycle → ir_valid=0 next cycle, no transfer counted, next fetch from the loaded address.
